// File: rtl/snake_pkg.sv
// Shared snake-game definitions: direction encoding, PS/2 set-2 make codes,
// key command decoding and the opposite-direction helper.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam logic [7:0] KEY_UP_A      = 8'h75;
  localparam logic [7:0] KEY_UP_B      = 8'h1D;
  localparam logic [7:0] KEY_DOWN_A    = 8'h72;
  localparam logic [7:0] KEY_DOWN_B    = 8'h1B;
  localparam logic [7:0] KEY_LEFT_A    = 8'h6B;
  localparam logic [7:0] KEY_LEFT_B    = 8'h1C;
  localparam logic [7:0] KEY_RIGHT_A   = 8'h74;
  localparam logic [7:0] KEY_RIGHT_B   = 8'h23;
  localparam logic [7:0] KEY_PAUSE     = 8'h4D;
  localparam logic [7:0] KEY_RESTART   = 8'h29;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } run_state_e;

  typedef enum logic [1:0] {
    CMD_NONE    = 2'd0,
    CMD_DIR     = 2'd1,
    CMD_PAUSE   = 2'd2,
    CMD_RESTART = 2'd3
  } cmd_kind_e;

  typedef struct packed {
    cmd_kind_e  kind;
    logic [1:0] dir;
  } key_cmd_t;

  // Reverse direction: UP<->DOWN, RIGHT<->LEFT differ only in bit 1.
  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

  // Map a make code onto a command; unknown codes decode to CMD_NONE.
  function automatic key_cmd_t decode_key(input logic [7:0] code);
    key_cmd_t r;
    r.kind = CMD_NONE;
    r.dir  = DIR_UP;
    case (code)
      KEY_UP_A, KEY_UP_B:       begin r.kind = CMD_DIR; r.dir = DIR_UP;    end
      KEY_DOWN_A, KEY_DOWN_B:   begin r.kind = CMD_DIR; r.dir = DIR_DOWN;  end
      KEY_LEFT_A, KEY_LEFT_B:   begin r.kind = CMD_DIR; r.dir = DIR_LEFT;  end
      KEY_RIGHT_A, KEY_RIGHT_B: begin r.kind = CMD_DIR; r.dir = DIR_RIGHT; end
      KEY_PAUSE:                r.kind = CMD_PAUSE;
      KEY_RESTART:              r.kind = CMD_RESTART;
      default:                  r.kind = CMD_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small direction FIFO. A push into a full FIFO is accepted when a pop happens
// in the same cycle; flush empties it and wins over push/pop. The full flag is
// registered from the next-state occupancy.
module dir_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [1:0] din,
  output logic [1:0] dout,
  output logic [1:0] last,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] last_ptr;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          do_push, do_pop;

  assign do_push  = push && (!full_q || pop) && !flush;
  assign do_pop   = pop && (count_q != '0) && !flush;
  assign last_ptr = wr_ptr_q - AW'(1);

  assign dout  = mem_q[rd_ptr_q];
  assign last  = mem_q[last_ptr];
  assign full  = full_q;
  assign empty = (count_q == '0);

  // Pointer and occupancy next state; pointers wrap naturally modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
    full_d = (count_d == FULL_CNT);
  end

  // Control state register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/key_cmd_scheduler.sv
// Turns PS/2 key strobes into snake commands: queues direction changes,
// applies one per game tick, and handles pause and restart.
module key_cmd_scheduler
  import snake_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter logic [1:0] INIT_DIR = DIR_RIGHT
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       key_pressed,
  input  logic [7:0] key_pressed_code,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       step,
  output logic       paused,
  output logic       restart,
  output logic       fifo_full,
  output logic [7:0] drop_cnt
);

  run_state_e state_q, state_d;
  key_cmd_t   cmd;
  logic [1:0] dir_q, dir_d;
  logic [7:0] drop_q, drop_d;
  logic       step_q, step_d;
  logic       restart_q, restart_d;
  logic       key_restart, key_pause, key_dir;
  logic       flush, running, tick_run;
  logic       fifo_push, fifo_pop, fifo_empty, fifo_full_w;
  logic [1:0] fifo_head, fifo_last, ref_dir;
  logic       dir_accept, drop;

  assign cmd         = decode_key(key_pressed_code);
  assign key_restart = key_pressed && (cmd.kind == CMD_RESTART);
  assign key_pause   = key_pressed && (cmd.kind == CMD_PAUSE);
  assign key_dir     = key_pressed && (cmd.kind == CMD_DIR);
  assign running     = (state_q == ST_RUN);

  // Run/pause state register.
  always_ff @(posedge CLK) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Run/pause transitions; restart forces run, entering pause flushes the queue.
  always_comb begin
    state_d = state_q;
    flush   = 1'b0;
    if (key_restart) begin
      state_d = ST_RUN;
      flush   = 1'b1;
    end else if (key_pause) begin
      case (state_q)
        ST_RUN: begin
          state_d = ST_PAUSED;
          flush   = 1'b1;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Tick handling and direction-key filtering. Duplicates of the reference
  // direction are discarded; reverses are queued and rejected at pop time.
  always_comb begin
    tick_run   = tick && running && !key_restart;
    fifo_pop   = tick_run && !fifo_empty && !flush;
    ref_dir    = fifo_empty ? dir_q : fifo_last;
    dir_accept = key_dir && running && (cmd.dir != ref_dir);
    fifo_push  = dir_accept && (!fifo_full_w || fifo_pop);
    drop       = dir_accept && fifo_full_w && !fifo_pop;
    step_d     = tick_run;
    restart_d  = key_restart;
    dir_d      = dir_q;
    if (key_restart)
      dir_d = INIT_DIR;
    else if (fifo_pop && (fifo_head != opposite(dir_q)))
      dir_d = fifo_head;
    drop_d = drop_q;
    if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // Output and counter registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      dir_q     <= INIT_DIR;
      drop_q    <= 8'd0;
      step_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      dir_q     <= dir_d;
      drop_q    <= drop_d;
      step_q    <= step_d;
      restart_q <= restart_d;
    end
  end

  dir_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (flush),
    .din   (cmd.dir),
    .dout  (fifo_head),
    .last  (fifo_last),
    .full  (fifo_full_w),
    .empty (fifo_empty)
  );

  assign dir       = dir_q;
  assign step      = step_q;
  assign paused    = (state_q == ST_PAUSED);
  assign restart   = restart_q;
  assign fifo_full = fifo_full_w;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Directed bench for key_cmd_scheduler with hand-computed expectations.
module tb_key_cmd_scheduler;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       key_pressed = 1'b0;
  logic [7:0] key_pressed_code = 8'h00;
  logic       tick = 1'b0;
  logic [1:0] dir;
  logic       step, paused, restart, fifo_full;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  key_cmd_scheduler #(.DEPTH(4), .INIT_DIR(2'd1)) dut (
    .CLK              (CLK),
    .reset            (reset),
    .key_pressed      (key_pressed),
    .key_pressed_code (key_pressed_code),
    .tick             (tick),
    .dir              (dir),
    .step             (step),
    .paused           (paused),
    .restart          (restart),
    .fifo_full        (fifo_full),
    .drop_cnt         (drop_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present inputs for one clock edge; outputs are settled at the following negedge.
  task automatic drive(input logic kp, input logic [7:0] code, input logic tk);
    key_pressed      = kp;
    key_pressed_code = code;
    tick             = tk;
    @(negedge CLK);
    key_pressed      = 1'b0;
    key_pressed_code = 8'h00;
    tick             = 1'b0;
  endtask

  task automatic key(input logic [7:0] code);
    drive(1'b1, code, 1'b0);
  endtask

  task automatic do_tick();
    drive(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_dir", {6'd0, dir}, 8'd1);
    chk("rst_step", {7'd0, step}, 8'd0);
    chk("rst_paused", {7'd0, paused}, 8'd0);
    chk("rst_restart", {7'd0, restart}, 8'd0);
    chk("rst_full", {7'd0, fifo_full}, 8'd0);
    chk("rst_drop", drop_cnt, 8'd0);
    reset = 1'b0;

    // three plain ticks
    for (int i = 0; i < 3; i++) begin
      do_tick();
      chk("tick_step", {7'd0, step}, 8'd1);
      chk("tick_dir", {6'd0, dir}, 8'd1);
      drive(1'b0, 8'h00, 1'b0);
      chk("idle_step", {7'd0, step}, 8'd0);
    end

    // DOWN then LEFT, two ticks
    key(8'h72);
    key(8'h6B);
    chk("q2_full", {7'd0, fifo_full}, 8'd0);
    chk("q2_dir_hold", {6'd0, dir}, 8'd1);
    do_tick();
    chk("q2_dir_down", {6'd0, dir}, 8'd2);
    do_tick();
    chk("q2_dir_left", {6'd0, dir}, 8'd3);

    key(8'h29);
    chk("rs1_restart", {7'd0, restart}, 8'd1);
    chk("rs1_dir", {6'd0, dir}, 8'd1);
    drive(1'b0, 8'h00, 1'b0);
    chk("rs1_restart_end", {7'd0, restart}, 8'd0);

    // reverse pop rejected
    key(8'h6B);
    do_tick();
    chk("rev_dir", {6'd0, dir}, 8'd1);
    chk("rev_step", {7'd0, step}, 8'd1);

    // fill and overflow
    key(8'h75);
    key(8'h74);
    key(8'h72);
    chk("fill3_full", {7'd0, fifo_full}, 8'd0);
    key(8'h6B);
    chk("fill4_full", {7'd0, fifo_full}, 8'd1);
    key(8'h1D);
    chk("drop1", drop_cnt, 8'd1);
    key(8'h1B);
    chk("drop2", drop_cnt, 8'd2);
    chk("drop_full", {7'd0, fifo_full}, 8'd1);

    // push + pop on full FIFO
    drive(1'b1, 8'h23, 1'b1);
    chk("fpp_dir", {6'd0, dir}, 8'd0);
    chk("fpp_full", {7'd0, fifo_full}, 8'd1);
    chk("fpp_drop", drop_cnt, 8'd2);
    chk("fpp_step", {7'd0, step}, 8'd1);

    // restart with full FIFO
    key(8'h29);
    chk("rs2_restart", {7'd0, restart}, 8'd1);
    chk("rs2_dir", {6'd0, dir}, 8'd1);
    chk("rs2_full", {7'd0, fifo_full}, 8'd0);
    chk("rs2_drop", drop_cnt, 8'd2);

    // pause sequence
    key(8'h4D);
    chk("p_paused", {7'd0, paused}, 8'd1);
    do_tick();
    chk("p_tick_step", {7'd0, step}, 8'd0);
    key(8'h75);
    key(8'h4D);
    chk("p_unpaused", {7'd0, paused}, 8'd0);
    do_tick();
    chk("p_step", {7'd0, step}, 8'd1);
    chk("p_dir", {6'd0, dir}, 8'd1);

    // restart while paused with queued keys
    key(8'h72);
    key(8'h6B);
    key(8'h4D);
    chk("rp_paused", {7'd0, paused}, 8'd1);
    key(8'h29);
    chk("rp_restart", {7'd0, restart}, 8'd1);
    chk("rp_paused0", {7'd0, paused}, 8'd0);
    chk("rp_dir", {6'd0, dir}, 8'd1);
    do_tick();
    chk("rp_tick_dir", {6'd0, dir}, 8'd1);
    chk("rp_tick_step", {7'd0, step}, 8'd1);

    // restart with same-cycle tick, queue non-empty
    key(8'h72);
    drive(1'b1, 8'h29, 1'b1);
    chk("rt_step", {7'd0, step}, 8'd0);
    chk("rt_restart", {7'd0, restart}, 8'd1);
    do_tick();
    chk("rt_flush_dir", {6'd0, dir}, 8'd1);

    // push + tick on empty FIFO: no bypass
    drive(1'b1, 8'h72, 1'b1);
    chk("ept_dir", {6'd0, dir}, 8'd1);
    chk("ept_step", {7'd0, step}, 8'd1);
    do_tick();
    chk("ept_dir2", {6'd0, dir}, 8'd2);

    // reset mid-operation
    key(8'h75);
    reset = 1'b1;
    do_tick();
    chk("mr_step", {7'd0, step}, 8'd0);
    chk("mr_dir", {6'd0, dir}, 8'd1);
    chk("mr_drop", drop_cnt, 8'd0);
    reset = 1'b0;
    do_tick();
    chk("mr_tick_dir", {6'd0, dir}, 8'd1);

    // code without strobe and unknown code are ignored
    drive(1'b0, 8'h72, 1'b0);
    key(8'h5A);
    do_tick();
    chk("ign_dir", {6'd0, dir}, 8'd1);

    // drop counter saturation
    key(8'h75);
    key(8'h74);
    key(8'h72);
    key(8'h6B);
    for (int i = 0; i < 254; i++) key(8'h75);
    chk("sat_254", drop_cnt, 8'd254);
    key(8'h75);
    chk("sat_255", drop_cnt, 8'd255);
    for (int i = 0; i < 5; i++) key(8'h75);
    chk("sat_hold", drop_cnt, 8'd255);
    chk("sat_full", {7'd0, fifo_full}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
